// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the cache-side request/response handshake and the shared memory
// port seen by mem_rr_arbiter. The arbiter connects through the slave
// modport; the environment (caches + memory model) uses the master modport.
interface mem_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_PORTS);

  // cache-side request channel
  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]                 req_ready;

  // cache-side response channel
  logic [NUM_PORTS-1:0]                 resp_valid;
  logic [NUM_PORTS-1:0]                 resp_err;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] resp_rdata;
  logic [ID_W-1:0]                      grant_id;

  // shared memory port
  logic [ADDR_WIDTH-1:0]                mem_address;
  logic [DATA_WIDTH-1:0]                mem_write_data;
  logic                                 mem_read_req;
  logic                                 mem_write_req;
  logic [DATA_WIDTH-1:0]                mem_read_data;
  logic                                 mem_ready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_read_data, mem_ready,
    output req_ready, resp_valid, resp_err, resp_rdata, grant_id,
    output mem_address, mem_write_data, mem_read_req, mem_write_req
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_read_data, mem_ready,
    input  req_ready, resp_valid, resp_err, resp_rdata, grant_id,
    input  mem_address, mem_write_data, mem_read_req, mem_write_req
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Memory-side arbiter: NUM_PORTS cache ports share one memory port with a
// single transaction outstanding. Selection is round-robin (mode 0) or fixed
// priority, lowest index first (mode 1). Completion is returned as a one-cycle
// resp_valid pulse to the originating port; an optional timeout aborts a
// transaction memory never acknowledges and flags it with resp_err.
module mem_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic             clk,
  input logic             reset,
  mem_rr_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_PORTS);
  // The timeout counter only needs to reach TIMEOUT_CYCLES-1: the abort is
  // taken on the edge that closes the last allowed ISSUE cycle.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ID_W:0]   NUM_PORTS_W = (ID_W + 1)'(NUM_PORTS);
  localparam logic [ID_W-1:0] LAST_PORT   = ID_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [ID_W-1:0]         rr_ptr_reg;
  logic [ID_W-1:0]         grant_id_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic [ADDR_WIDTH-1:0]   mem_address_reg;
  logic [DATA_WIDTH-1:0]   mem_write_data_reg;
  logic                    mem_read_req_reg;
  logic                    mem_write_req_reg;
  logic [NUM_PORTS-1:0]    resp_valid_reg;
  logic [NUM_PORTS-1:0]    resp_err_reg;
  logic [DATA_WIDTH-1:0]   resp_rdata_reg [NUM_PORTS];

  logic [ID_W-1:0]         search_base;
  logic [ID_W-1:0]         winner_next;
  logic [ID_W:0]           cand;
  logic                    winner_found;
  logic                    accept;
  logic                    rdata_we;
  logic [NUM_PORTS-1:0]    grant_onehot;

  // Winner search: scan from the far end back toward the search base so the
  // last hit (closest to the base, with wrap) is the one that sticks.
  always_comb begin
    search_base  = (PRIORITY_MODE == 0) ? rr_ptr_reg : '0;
    winner_next  = '0;
    cand         = '0;
    winner_found = |bus.req_valid;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, search_base} + (ID_W + 1)'(k);
      if (cand >= NUM_PORTS_W) begin
        cand = cand - NUM_PORTS_W;
      end
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        winner_next = cand[ID_W-1:0];
      end
    end
  end

  // A transfer happens whenever IDLE sees any valid request: the winner is
  // valid by construction, so its ready and valid are both high.
  assign accept   = (state_reg == IDLE) && winner_found;
  // Read data is captured only on a successful read completion.
  assign rdata_we = (state_reg == ISSUE) && bus.mem_ready && mem_read_req_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign bus.req_ready[gi]  = accept && (winner_next == ID_W'(gi));
      assign grant_onehot[gi]   = (grant_id_reg == ID_W'(gi));
      assign bus.resp_rdata[gi] = resp_rdata_reg[gi];

      // Per-port read-data holding register, updated on read responses only.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          resp_rdata_reg[gi] <= '0;
        end else if (rdata_we && grant_onehot[gi]) begin
          resp_rdata_reg[gi] <= bus.mem_read_data;
        end
      end
    end
  endgenerate

  assign bus.resp_valid     = resp_valid_reg;
  assign bus.resp_err       = resp_err_reg;
  assign bus.grant_id       = grant_id_reg;
  assign bus.mem_address    = mem_address_reg;
  assign bus.mem_write_data = mem_write_data_reg;
  assign bus.mem_read_req   = mem_read_req_reg;
  assign bus.mem_write_req  = mem_write_req_reg;

  // Control FSM: accept in IDLE, hold the memory request in ISSUE until
  // mem_ready or timeout, pulse the response in RESP and advance rr_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      rr_ptr_reg         <= '0;
      grant_id_reg       <= '0;
      to_cnt_reg         <= '0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      mem_read_req_reg   <= 1'b0;
      mem_write_req_reg  <= 1'b0;
      resp_valid_reg     <= '0;
      resp_err_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_valid_reg <= '0;
          resp_err_reg   <= '0;
          if (accept) begin
            grant_id_reg       <= winner_next;
            mem_address_reg    <= bus.req_addr[winner_next];
            mem_write_data_reg <= bus.req_wdata[winner_next];
            mem_read_req_reg   <= ~bus.req_write[winner_next];
            mem_write_req_reg  <= bus.req_write[winner_next];
            to_cnt_reg         <= '0;
            state_reg          <= ISSUE;
          end
        end

        ISSUE: begin
          // mem_ready wins over a timeout landing on the same edge.
          if (bus.mem_ready) begin
            mem_read_req_reg  <= 1'b0;
            mem_write_req_reg <= 1'b0;
            resp_valid_reg    <= grant_onehot;
            resp_err_reg      <= '0;
            to_cnt_reg        <= '0;
            state_reg         <= RESP;
          end else if ((TIMEOUT_CYCLES > 0) && (to_cnt_reg == TO_LAST)) begin
            mem_read_req_reg  <= 1'b0;
            mem_write_req_reg <= 1'b0;
            resp_valid_reg    <= grant_onehot;
            resp_err_reg      <= grant_onehot;
            to_cnt_reg        <= '0;
            state_reg         <= RESP;
          end else if (TIMEOUT_CYCLES > 0) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        RESP: begin
          resp_valid_reg <= '0;
          resp_err_reg   <= '0;
          if (PRIORITY_MODE == 0) begin
            rr_ptr_reg <= (grant_id_reg == LAST_PORT) ? '0 : grant_id_reg + 1'b1;
          end
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a round-robin instance with an 8-cycle
// timeout and a fixed-priority instance without timeout share clk/reset.
// Single-port transactions come from a vector table; arbitration order,
// timeout, mid-transaction reset and fixed priority are hand sequences.
module tb_mem_rr_arbiter;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  mem_rr_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_rr ();
  mem_rr_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_fp ();

  mem_rr_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr)
  );

  mem_rr_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
  ) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;          // cycles until mem_ready
    logic [31:0] mem_rdata;  // value memory drives on the ready edge
    logic [31:0] exp_rdata;  // resp_rdata[port] expected after completion
  } vec_t;

  // One single-port transaction on the round-robin instance, starting and
  // ending at a falling edge in IDLE.
  task automatic rr_txn(input int port, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int k,
                        input logic [31:0] mdata, input logic [31:0] exp_rdata);
    logic [3:0] onehot;
    onehot = 4'b0001 << port;
    bus_rr.req_valid       = onehot;
    bus_rr.req_write[port] = wr;
    bus_rr.req_addr[port]  = addr;
    bus_rr.req_wdata[port] = wdata;
    #1;
    check("req_ready", 64'(bus_rr.req_ready), 64'(onehot));
    @(negedge clk);
    // Latched values must be used from here on.
    bus_rr.req_valid       = '0;
    bus_rr.req_write[port] = ~wr;
    bus_rr.req_addr[port]  = ~addr;
    bus_rr.req_wdata[port] = ~wdata;
    check("grant_id", 64'(bus_rr.grant_id), 64'(port));
    check("ready_in_issue", 64'(bus_rr.req_ready), 64'h0);
    for (int j = 1; j <= k; j++) begin
      check("mem_read_req", 64'(bus_rr.mem_read_req), 64'(!wr));
      check("mem_write_req", 64'(bus_rr.mem_write_req), 64'(wr));
      check("mem_address", 64'(bus_rr.mem_address), 64'(addr));
      if (wr) check("mem_write_data", 64'(bus_rr.mem_write_data), 64'(wdata));
      if (j == k) begin
        bus_rr.mem_ready     = 1'b1;
        bus_rr.mem_read_data = mdata;
      end
      @(negedge clk);
      bus_rr.mem_ready     = 1'b0;
      bus_rr.mem_read_data = 32'h0BAD_0BAD;
    end
    check("resp_valid", 64'(bus_rr.resp_valid), 64'(onehot));
    check("resp_err", 64'(bus_rr.resp_err), 64'h0);
    check("req_dropped", 64'({bus_rr.mem_read_req, bus_rr.mem_write_req}), 64'h0);
    check("resp_rdata", 64'(bus_rr.resp_rdata[port]), 64'(exp_rdata));
    @(negedge clk);
    check("resp_valid_clear", 64'(bus_rr.resp_valid), 64'h0);
    $display("txn port=%0d %s addr=0x%08h k=%0d rdata=0x%08h", port,
             wr ? "WR" : "RD", addr, k, bus_rr.resp_rdata[port]);
  endtask

  vec_t vecs[8];
  int   exp_order[5];
  int   cnt;

  initial begin
    vecs[0] = '{port: 0, wr: 1'b1, addr: 32'h40,  wdata: 32'hA5A5A5A5, k: 3, mem_rdata: 32'hFFFF0000, exp_rdata: 32'h0};
    vecs[1] = '{port: 2, wr: 1'b0, addr: 32'h100, wdata: 32'h0,        k: 1, mem_rdata: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{port: 0, wr: 1'b0, addr: 32'h44,  wdata: 32'h0,        k: 2, mem_rdata: 32'h12345678, exp_rdata: 32'h12345678};
    vecs[3] = '{port: 0, wr: 1'b1, addr: 32'h48,  wdata: 32'h0,        k: 1, mem_rdata: 32'hFFFFFFFF, exp_rdata: 32'h12345678};
    vecs[4] = '{port: 3, wr: 1'b0, addr: 32'h1FC, wdata: 32'h0,        k: 4, mem_rdata: 32'hCAFEF00D, exp_rdata: 32'hCAFEF00D};
    vecs[5] = '{port: 1, wr: 1'b0, addr: 32'h200, wdata: 32'h0,        k: 8, mem_rdata: 32'h33334444, exp_rdata: 32'h33334444};
    vecs[6] = '{port: 2, wr: 1'b1, addr: 32'h104, wdata: 32'h55AA55AA, k: 2, mem_rdata: 32'h00000000, exp_rdata: 32'hDEADBEEF};
    vecs[7] = '{port: 1, wr: 1'b0, addr: 32'h204, wdata: 32'h0,        k: 1, mem_rdata: 32'h11112222, exp_rdata: 32'h11112222};
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    bus_rr.req_valid = '0; bus_rr.req_write = '0; bus_rr.req_addr = '0; bus_rr.req_wdata = '0;
    bus_rr.mem_ready = 1'b0; bus_rr.mem_read_data = '0;
    bus_fp.req_valid = '0; bus_fp.req_write = '0; bus_fp.req_addr = '0; bus_fp.req_wdata = '0;
    bus_fp.mem_ready = 1'b0; bus_fp.mem_read_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_mem_read_req", 64'(bus_rr.mem_read_req), 64'h0);
    check("rst_mem_write_req", 64'(bus_rr.mem_write_req), 64'h0);
    check("rst_mem_address", 64'(bus_rr.mem_address), 64'h0);
    check("rst_mem_write_data", 64'(bus_rr.mem_write_data), 64'h0);
    check("rst_resp_valid", 64'(bus_rr.resp_valid), 64'h0);
    check("rst_resp_err", 64'(bus_rr.resp_err), 64'h0);
    check("rst_grant_id", 64'(bus_rr.grant_id), 64'h0);
    check("rst_req_ready", 64'(bus_rr.req_ready), 64'h0);
    for (int p = 0; p < 4; p++)
      check($sformatf("rst_rdata%0d", p), 64'(bus_rr.resp_rdata[p]), 64'h0);
    check("rst_fp_outputs", 64'({bus_fp.mem_read_req, bus_fp.mem_write_req, bus_fp.resp_valid}), 64'h0);

    // Table-driven single-port transactions
    for (int v = 0; v < 8; v++)
      rr_txn(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
             vecs[v].k, vecs[v].mem_rdata, vecs[v].exp_rdata);

    // Timeout: mem_ready never arrives, request drops after 8 ISSUE cycles
    bus_rr.req_valid    = 4'b0010;
    bus_rr.req_write[1] = 1'b0;
    bus_rr.req_addr[1]  = 32'h300;
    #1;
    check("to_req_ready", 64'(bus_rr.req_ready), 64'h2);
    @(negedge clk);
    bus_rr.req_valid = '0;
    cnt = 0;
    while (bus_rr.mem_read_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("to_issue_cycles", 64'(cnt), 64'd8);
    check("to_resp_valid", 64'(bus_rr.resp_valid), 64'h2);
    check("to_resp_err", 64'(bus_rr.resp_err), 64'h2);
    check("to_rdata_kept", 64'(bus_rr.resp_rdata[1]), 64'h11112222);
    @(negedge clk);
    check("to_pulse_clear", 64'({bus_rr.resp_valid, bus_rr.resp_err}), 64'h0);
    $display("txn port=1 RD addr=0x00000300 timeout after %0d cycles", cnt);

    // Round-robin order with all ports valid from reset
    reset = 1'b1;
    bus_rr.req_write = '0;
    bus_rr.req_valid = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("rr_req_ready", 64'(bus_rr.req_ready), 64'(4'b0001 << exp_order[n]));
      @(negedge clk);
      check("rr_grant_id", 64'(bus_rr.grant_id), 64'(exp_order[n]));
      bus_rr.mem_ready     = 1'b1;
      bus_rr.mem_read_data = 32'h1000 + 32'(n);
      @(negedge clk);
      bus_rr.mem_ready = 1'b0;
      check("rr_resp_valid", 64'(bus_rr.resp_valid), 64'(4'b0001 << exp_order[n]));
      check("rr_no_accept_in_resp", 64'(bus_rr.req_ready), 64'h0);
      check("rr_rdata", 64'(bus_rr.resp_rdata[exp_order[n]]), 64'h1000 + 64'(n));
      $display("txn rr n=%0d grant=%0d", n, bus_rr.grant_id);
      @(negedge clk);
    end
    bus_rr.req_valid = '0;

    // Reset mid-ISSUE, late mem_ready ignored, rr_ptr back to 0
    rr_txn(2, 1'b0, 32'h108, 32'h0, 1, 32'h0000ABCD, 32'h0000ABCD);
    bus_rr.req_valid    = 4'b1000;
    bus_rr.req_write[3] = 1'b0;
    bus_rr.req_addr[3]  = 32'h500;
    @(negedge clk);
    bus_rr.req_valid = '0;
    check("mr_in_issue", 64'(bus_rr.mem_read_req), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_async_req", 64'({bus_rr.mem_read_req, bus_rr.mem_write_req}), 64'h0);
    check("mr_async_addr", 64'(bus_rr.mem_address), 64'h0);
    check("mr_async_grant", 64'(bus_rr.grant_id), 64'h0);
    check("mr_async_rdata2", 64'(bus_rr.resp_rdata[2]), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_rr.mem_ready     = 1'b1;
    bus_rr.mem_read_data = 32'h77;
    @(negedge clk);
    bus_rr.mem_ready = 1'b0;
    check("mr_late_ready_valid", 64'(bus_rr.resp_valid), 64'h0);
    check("mr_late_ready_rdata", 64'(bus_rr.resp_rdata[3]), 64'h0);
    @(negedge clk);
    check("mr_late_ready_valid2", 64'(bus_rr.resp_valid), 64'h0);
    bus_rr.req_valid = 4'b1010;
    bus_rr.req_write = '0;
    #1;
    check("mr_ptr_zero", 64'(bus_rr.req_ready), 64'h2);
    @(negedge clk);
    bus_rr.req_valid = '0;
    check("mr_grant", 64'(bus_rr.grant_id), 64'h1);
    bus_rr.mem_ready     = 1'b1;
    bus_rr.mem_read_data = 32'h600D;
    @(negedge clk);
    bus_rr.mem_ready = 1'b0;
    check("mr_resp_valid", 64'(bus_rr.resp_valid), 64'h2);
    check("mr_rdata", 64'(bus_rr.resp_rdata[1]), 64'h600D);
    $display("txn after reset port=%0d rdata=0x%08h", bus_rr.grant_id, bus_rr.resp_rdata[1]);
    @(negedge clk);

    // Fixed priority: ports 1 and 3 valid, port 1 always wins; no timeout
    bus_fp.req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("fp_req_ready", 64'(bus_fp.req_ready), 64'h2);
      @(negedge clk);
      check("fp_grant", 64'(bus_fp.grant_id), 64'h1);
      if (n == 0) begin
        for (int w = 0; w < 12; w++) begin
          check("fp_no_timeout", 64'(bus_fp.mem_read_req), 64'h1);
          @(negedge clk);
        end
      end
      bus_fp.mem_ready     = 1'b1;
      bus_fp.mem_read_data = 32'hF000 + 32'(n);
      @(negedge clk);
      bus_fp.mem_ready = 1'b0;
      check("fp_resp_valid", 64'(bus_fp.resp_valid), 64'h2);
      check("fp_resp_err", 64'(bus_fp.resp_err), 64'h0);
      $display("txn fp n=%0d grant=%0d rdata=0x%08h", n, bus_fp.grant_id, bus_fp.resp_rdata[1]);
      @(negedge clk);
    end
    bus_fp.req_valid = 4'b1000;
    #1;
    check("fp_port3_ready", 64'(bus_fp.req_ready), 64'h8);
    @(negedge clk);
    bus_fp.req_valid = '0;
    check("fp_port3_grant", 64'(bus_fp.grant_id), 64'h3);
    bus_fp.mem_ready = 1'b1;
    @(negedge clk);
    bus_fp.mem_ready = 1'b0;
    check("fp_port3_resp", 64'(bus_fp.resp_valid), 64'h8);
    $display("txn fp port=3 grant=%0d", bus_fp.grant_id);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
